fifo_parity_checker: RTL

Pop-side consumer for the parity-protected FIFO. It drains words through the FIFO's pop valid/grant handshake and splits each word into data and parity bit. Good words are forwarded to a downstream valid/grant port through a one-entry output register; bad words are counted and flagged. After a programmable number of errors it stops popping until software clears the errors.

---
 rtl/fifo_parity_pkg.sv | 20 ++
 rtl/fifo_parity_checker.sv | 116 +++++++++++
 2 files changed

// File: rtl/fifo_parity_pkg.sv
// Shared types and helpers for the FIFO pop-side parity checker.
//   chk_state_t : checker FSM state (RUN / HALTED)
//   parity_ok   : parity verdict for a word, zero-extended to PARITY_MAX_WIDTH
package fifo_parity_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } chk_state_t;

    // Widest word the helper accepts; zero-extension does not change the XOR.
    localparam int unsigned PARITY_MAX_WIDTH = 64;

    // Good when the XOR of every bit (payload + parity) equals the odd select.
    function automatic logic parity_ok(input logic [PARITY_MAX_WIDTH-1:0] word,
                                       input logic                        odd);
        return (^word) == odd;
    endfunction

endpackage

// File: rtl/fifo_parity_checker.sv
// Pop-side consumer for a parity-protected FIFO.
// Drains words via a valid/grant handshake, checks parity, forwards good words
// through a one-entry output register and counts bad words. After ERR_LIMIT
// errors the checker halts popping until err_clr_in.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   pop_valid_in / pop_grant_out : FIFO pop handshake (grant is combinational)
//   pop_data_in                  : FIFO head word, MSB is the parity bit
//   out_valid_out / out_grant_in : downstream handshake
//   out_data_out, out_err_out    : payload and bad-parity marker
//   err_flag_out, err_count_out  : sticky flag, saturating bad-word count
//   halted_out                   : checker is halted on the error limit
//   err_clr_in                   : clears count/flag and releases the halt
module fifo_parity_checker
    import fifo_parity_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 17,
    parameter bit          PARITY_ODD    = 1'b0,
    parameter bit          DROP_ON_ERR   = 1'b1,
    parameter int unsigned ERR_CNT_WIDTH = 8,
    parameter int unsigned ERR_LIMIT     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pop_valid_in,
    output logic                     pop_grant_out,
    input  logic [DATA_WIDTH-1:0]    pop_data_in,
    output logic                     out_valid_out,
    input  logic                     out_grant_in,
    output logic [DATA_WIDTH-2:0]    out_data_out,
    output logic                     out_err_out,
    output logic                     err_flag_out,
    output logic [ERR_CNT_WIDTH-1:0] err_count_out,
    output logic                     halted_out,
    input  logic                     err_clr_in
);

    localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [ERR_CNT_WIDTH-1:0] CNT_LIMIT = ERR_CNT_WIDTH'(ERR_LIMIT);
    localparam bit                       HALT_EN   = (ERR_LIMIT != 0);

    chk_state_t               state;
    chk_state_t               state_next;
    logic                     pop_fire;
    logic                     par_ok;
    logic                     bad_pop;
    logic                     load;
    logic [ERR_CNT_WIDTH-1:0] count_inc;

    // Grant only in RUN with room in the output register; never during reset.
    assign pop_grant_out = (state == RUN) & (~out_valid_out | out_grant_in) & ~rst;
    assign pop_fire      = pop_valid_in & pop_grant_out;
    assign par_ok        = parity_ok(PARITY_MAX_WIDTH'(pop_data_in), PARITY_ODD);
    assign bad_pop       = pop_fire & ~par_ok;
    assign load          = pop_fire & (par_ok | ~DROP_ON_ERR);
    assign count_inc     = (err_count_out == CNT_MAX) ? err_count_out
                                                      : err_count_out + ERR_CNT_WIDTH'(1);
    assign halted_out    = (state == HALTED);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state; a clear coincident with the limit-reaching pop keeps RUN.
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (HALT_EN && bad_pop && !err_clr_in && (count_inc == CNT_LIMIT)) begin
                    state_next = HALTED;
                end
            end
            HALTED: begin
                if (err_clr_in) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // One-entry output register; a dropped word lets it empty on a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_out <= 1'b0;
            out_data_out  <= '0;
            out_err_out   <= 1'b0;
        end else if (load) begin
            out_valid_out <= 1'b1;
            out_data_out  <= pop_data_in[DATA_WIDTH-2:0];
            out_err_out   <= ~par_ok;
        end else if (out_grant_in) begin
            out_valid_out <= 1'b0;
        end
    end

    // Error counter and sticky flag; clear has priority but still counts a same-cycle bad pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_out <= '0;
            err_flag_out  <= 1'b0;
        end else if (err_clr_in) begin
            err_count_out <= bad_pop ? ERR_CNT_WIDTH'(1) : '0;
            err_flag_out  <= bad_pop;
        end else if (bad_pop) begin
            err_count_out <= count_inc;
            err_flag_out  <= 1'b1;
        end
    end

endmodule
